// File: rtl/delta_scan_engine.sv
// Delta-memory scanner: FIND/MADD walk DEPTH entries, one entry per cycle, either direction.
// Latency: FIND hit at visit k done k+1 edges after run, miss after DEPTH edges, MADD after DEPTH+1 edges; commands are ignored while busy.
module delta_scan_engine #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int MW    = DW + 2,
  parameter int OW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] data,
  input  logic [1:0]    insn,
  input  logic          load,
  input  logic          run,
  output logic [OW-1:0] out,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINAL} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] mem_d [DEPTH];
  logic          dir_up_q, dir_up_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] k_q, k_d;
  logic          madd_q, madd_d;
  logic [OW-1:0] delta_q, delta_d;
  logic [OW-1:0] count_q, count_d;
  logic [OW-1:0] total_q, total_d;
  logic [OW-1:0] out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic          err_q, err_d;

  logic [AW-1:0] scan_addr;
  logic [AW-1:0] index_m1;
  logic [MW-1:0] data_ext;
  logic [MW-1:0] mem_sel;
  logic [OW-1:0] mem_sext;

  always_comb begin
    scan_addr = dir_up_q ? (start_q + k_q) : (start_q - k_q);
    index_m1  = index - AW'(1);
    data_ext  = {{(MW-DW){1'b0}}, data};
    mem_sel   = mem_q[scan_addr];
    mem_sext  = {{(OW-MW){mem_sel[MW-1]}}, mem_sel};
  end

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    dir_up_d = dir_up_q;
    start_d  = start_q;
    k_d      = k_q;
    madd_d   = madd_q;
    delta_d  = delta_q;
    count_d  = count_q;
    total_d  = total_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (load && run) begin
          err_d = 1'b1;
        end else if (load) begin
          case (insn)
            2'b00: mem_d[index] = data_ext;
            2'b01: begin
              mem_d[index] = mem_q[index] + data_ext;
              // Index 0 has no lower neighbour; the pair update does not wrap.
              if (index != '0) mem_d[index_m1] = mem_q[index_m1] - data_ext;
            end
            2'b10: mem_d[index] = '0;
            default: err_d = 1'b1;
          endcase
        end else if (run) begin
          if (insn[1]) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SCAN;
            busy_d  = 1'b1;
            found_d = 1'b0;
            k_d     = '0;
            madd_d  = insn[0];
            delta_d = '0;
            count_d = '0;
            total_d = '0;
          end
        end else begin
          case (insn)
            2'b00: begin
              dir_up_d = 1'b1;
              start_d  = '0;
            end
            2'b01: begin
              dir_up_d = 1'b0;
              start_d  = LAST;
            end
            2'b10: for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            default: ;
          endcase
        end
      end

      S_SCAN: begin
        k_d = k_q + AW'(1);
        if (!madd_q) begin
          if (mem_sel != '0) begin
            out_d   = {{(OW-AW){1'b0}}, scan_addr};
            found_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (k_q == LAST) begin
            out_d   = '0;
            found_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          // Double integration: all three terms advance from pre-visit values.
          total_d = total_q + count_q;
          count_d = count_q + delta_q;
          delta_d = delta_q + mem_sext;
          if (k_q == LAST) state_d = S_FINAL;
        end
      end

      S_FINAL: begin
        out_d   = total_q + count_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dir_up_q <= 1'b0;
      start_q  <= LAST;
      k_q      <= '0;
      madd_q   <= 1'b0;
      delta_q  <= '0;
      count_q  <= '0;
      total_q  <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      dir_up_q <= dir_up_d;
      start_q  <= start_d;
      k_q      <= k_d;
      madd_q   <= madd_d;
      delta_q  <= delta_d;
      count_q  <= count_d;
      total_q  <= total_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign out   = out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign err   = err_q;

endmodule

// File: tb/tb_delta_scan_engine.sv
// Directed bench for delta_scan_engine: stimulus pushes expected results, a monitor checks each done pulse.
module tb_delta_scan_engine;

  logic        clk;
  logic        rst_n;
  logic [3:0]  index;
  logic [3:0]  data;
  logic [1:0]  insn;
  logic        load;
  logic        run;
  logic [11:0] out;
  logic        busy;
  logic        done;
  logic        found;
  logic        err;

  typedef struct {
    logic [11:0] out;
    logic        found;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   busy_total = 0;
  int   e0;
  int   busy_snap;

  delta_scan_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index),
    .data  (data),
    .insn  (insn),
    .load  (load),
    .run   (run),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .found (found),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One command per call; accepted at the next rising edge, then inputs park on a no-op.
  task automatic drive(input logic l, input logic r, input logic [1:0] i,
                       input logic [3:0] idx, input logic [3:0] d);
    @(negedge clk);
    load = l; run = r; insn = i; index = idx; data = d;
    @(posedge clk);
    #1;
    load = 1'b0; run = 1'b0; insn = 2'b11;
  endtask

  task automatic expect_done(input int o, input logic f, input int lat);
    exp_t e;
    e.out = o[11:0];
    e.found = f;
    e.edge_no = e0 + lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] i, input int o,
                        input logic f, input int lat);
    drive(1'b0, 1'b1, i, 4'd0, 4'd0);
    e0 = edge_cnt;
    expect_done(o, f, lat);
    chk({name, "_busy_after_accept"}, int'(busy), 1);
    chk({name, "_found_cleared"}, int'(found), 0);
    wait_drain(name);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_out"}, int'(out), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_found"}, int'(found), 0);
    chk({name, "_err"}, int'(err), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(name);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; load = 1'b0; run = 1'b0; insn = 2'b11; index = '0; data = '0;
    #2 rst_n = 1'b0;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (busy) busy_total++;
          if (done) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done: out=%0d at edge %0d, none expected", out, edge_cnt);
            end else begin
              e = sb.pop_front();
              chk("done_out", int'(out), int'(e.out));
              chk("done_found", int'(found), int'(e.found));
              chk("done_edge", edge_cnt, e.edge_no);
            end
          end
        end
      end
      begin : stimulus
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Default MAX mode: walk 15 down, first hit at entry 5.
        drive(1'b1, 1'b0, 2'b00, 4'd5, 4'd3);
        drive(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
        e0 = edge_cnt;
        expect_done(5, 1'b1, 11);
        chk("find_max_busy", int'(busy), 1);
        repeat (2) @(posedge clk);
        drive(1'b1, 1'b0, 2'b00, 4'd15, 4'd1);
        chk("load_in_scan_err", int'(err), 0);
        wait_drain("find_max");

        run_op("madd_45", 2'b01, 45, 1'b0, 17);

        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 2'b00, 4'd9, 4'd1);
        run_op("find_min", 2'b00, 5, 1'b1, 6);

        drive(1'b0, 1'b0, 2'b10, 4'd0, 4'd0);
        busy_snap = busy_total;
        run_op("find_miss", 2'b00, 0, 1'b0, 16);
        chk("miss_busy_cycles", busy_total - busy_snap, 16);

        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 2'b01, 4'd7, 4'd2);
        run_op("madd_neg", 2'b01, 4078, 1'b0, 17);

        // Pair update at index 0 must not touch entry 15.
        drive(1'b1, 1'b0, 2'b01, 4'd0, 4'd1);
        drive(1'b0, 1'b0, 2'b01, 4'd0, 4'd0);
        run_op("idx0_no_wrap", 2'b00, 7, 1'b1, 9);
        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        run_op("find_at_0", 2'b00, 0, 1'b1, 1);

        chk("err_clean", int'(err), 0);
        drive(1'b1, 1'b1, 2'b00, 4'd12, 4'd9);
        chk("load_run_err", int'(err), 1);
        chk("load_run_busy", int'(busy), 0);
        drive(1'b0, 1'b0, 2'b01, 4'd0, 4'd0);
        run_op("load_run_nowrite", 2'b00, 7, 1'b1, 9);

        do_reset("reset2");
        drive(1'b0, 1'b1, 2'b10, 4'd0, 4'd0);
        chk("run_1x_err", int'(err), 1);
        chk("run_1x_busy", int'(busy), 0);

        do_reset("reset3");
        drive(1'b1, 1'b0, 2'b11, 4'd3, 4'd4);
        chk("load_11_err", int'(err), 1);
        run_op("load_11_nowrite", 2'b00, 0, 1'b0, 16);

        drive(1'b1, 1'b0, 2'b00, 4'd2, 4'd5);
        run_op("find_2", 2'b00, 2, 1'b1, 14);
        drive(1'b0, 1'b1, 2'b01, 4'd0, 4'd0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_scan_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset_miss", 2'b00, 0, 1'b0, 16);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule
